// File: rtl/coin_payout_ctrl.sv
// Coin payout transmitter: pays an amount in 50-cent units as a greedy sequence of
// timed coin pulses, honouring tube-empty flags and reporting done or fault.
module coin_payout_ctrl #(
  parameter int unsigned AMT_W        = 4,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             tube_1e_empty_i,
  input  logic             tube_50_empty_i,
  output logic [1:0]       coin_code_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [AMT_W-1:0] remaining_o
);

  localparam int unsigned MaxCycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;

  localparam logic [TimerW-1:0] PulseLast = TimerW'(PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast   = TimerW'(GAP_CYCLES - 1);

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] Coin50   = 2'b01;
  localparam logic [1:0] Coin1e   = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StGap,
    StDone,
    StFault
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          coin_q, coin_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic [AMT_W-1:0]    sel_src;
  logic [1:0]          sel;
  logic [AMT_W-1:0]    sel_val;

  // Greedy choice: prefer 1 euro when at least two units remain and the tube has coins.
  function automatic logic [1:0] sel_coin(input logic [AMT_W-1:0] r,
                                          input logic             empty_1e,
                                          input logic             empty_50);
    if (r > AMT_W'(1) && !empty_1e) begin
      return Coin1e;
    end else if (r != '0 && !empty_50) begin
      return Coin50;
    end
    return CoinNone;
  endfunction

  // Selection looks at the new amount when launching, at the remainder between coins.
  assign sel_src = (state_q == StGap) ? rem_q : amount_i;
  assign sel     = sel_coin(sel_src, tube_1e_empty_i, tube_50_empty_i);
  assign sel_val = (sel == Coin1e) ? AMT_W'(2) : AMT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      coin_q  <= CoinNone;
      rem_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle, StFault: begin
        if (start_i) begin
          timer_d = '0;
          if (amount_i == '0) begin
            state_d = StDone;
            rem_d   = '0;
          end else if (sel != CoinNone) begin
            state_d = StEmit;
            coin_d  = sel;
            rem_d   = amount_i - sel_val;
          end else begin
            state_d = StFault;
            rem_d   = amount_i;
          end
        end
      end
      StEmit: begin
        if (timer_q == PulseLast) begin
          state_d = StGap;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (rem_q == '0) begin
            state_d = StDone;
          end else if (sel != CoinNone) begin
            state_d = StEmit;
            coin_d  = sel;
            rem_d   = rem_q - sel_val;
          end else begin
            state_d = StFault;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    coin_code_o = CoinNone;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    fault_o     = 1'b0;
    remaining_o = rem_q;
    unique case (state_q)
      StEmit: begin
        coin_code_o = coin_q;
        busy_o      = 1'b1;
      end
      StGap:   busy_o = 1'b1;
      StDone: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      StFault: fault_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Self-checking bench for coin_payout_ctrl: directed plan scenarios plus randomized payouts
// compared cycle by cycle against a trace model built from the payout rules.
module tb_coin_payout_ctrl;

  localparam int unsigned AMT_W = 4;
  localparam int unsigned PULSE = 4;
  localparam int unsigned GAP   = 2;

  typedef struct packed {
    logic [1:0]       code;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] rem;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [AMT_W-1:0] amount_i = '0;
  logic             tube_1e_empty_i = 1'b0;
  logic             tube_50_empty_i = 1'b0;
  logic [1:0]       coin_code_o;
  logic             busy_o, done_o, fault_o;
  logic [AMT_W-1:0] remaining_o;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  coin_payout_ctrl #(
    .AMT_W       (AMT_W),
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .amount_i       (amount_i),
    .tube_1e_empty_i(tube_1e_empty_i),
    .tube_50_empty_i(tube_50_empty_i),
    .coin_code_o    (coin_code_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fault_o        (fault_o),
    .remaining_o    (remaining_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{code: coin_code_o, busy: busy_o, done: done_o, fault: fault_o, rem: remaining_o};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("code=%b busy=%b done=%b fault=%b rem=%0d", o.code, o.busy, o.done, o.fault,
                     o.rem);
  endfunction

  function automatic obs_t mk(input logic [1:0] c, input bit b, input bit d, input bit f,
                              input int r);
    return '{code: c, busy: b, done: d, fault: f, rem: AMT_W'(r)};
  endfunction

  // Expected per-cycle outputs from cycle 1 after the accepted start, tubes held constant.
  task automatic model_trace(input int amt, input bit e1, input bit e50);
    int r = amt;
    logic [1:0] c;
    exp_q.delete();
    if (r == 0) begin
      exp_q.push_back(mk(2'b00, 1, 1, 0, 0));
      exp_q.push_back(mk(2'b00, 0, 0, 0, 0));
      return;
    end
    while (1) begin
      if (r >= 2 && !e1) c = 2'b10;
      else if (r >= 1 && !e50) c = 2'b01;
      else c = 2'b00;
      if (c == 2'b00) begin
        repeat (3) exp_q.push_back(mk(2'b00, 0, 0, 1, r));
        return;
      end
      r -= (c == 2'b10) ? 2 : 1;
      repeat (PULSE) exp_q.push_back(mk(c, 1, 0, 0, r));
      repeat (GAP) exp_q.push_back(mk(2'b00, 1, 0, 0, r));
      if (r == 0) begin
        exp_q.push_back(mk(2'b00, 1, 1, 0, 0));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0));
        return;
      end
    end
  endtask

  // Starts a payout and records exp_q.size() cycles; optional start noise while busy.
  task automatic drive_payout(input int amt, input bit e1, input bit e50, input bit rnd_noise,
                              input int noise_cyc);
    int n = exp_q.size();
    obs_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    amount_i = AMT_W'(amt);
    tube_1e_empty_i = e1;
    tube_50_empty_i = e50;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      obs_q.push_back(sample());
      if (exp_q[i].busy && !exp_q[i].done) begin
        if (rnd_noise) begin
          start_i = 1'($urandom_range(0, 1));
          amount_i = AMT_W'($urandom);
        end
        if (i + 1 == noise_cyc) begin
          start_i = 1'b1;
          amount_i = AMT_W'(1);
        end
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== mk(2'b00, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_values: got %s, expected all zero", fmt(o));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plan_table();
    int amts[5] = '{3, 0, 2, 1, 1};
    bit e1s[5]  = '{0, 0, 1, 0, 0};
    bit e50s[5] = '{0, 0, 0, 1, 0};
    for (int t = 0; t < 5; t++) begin
      model_trace(amts[t], e1s[t], e50s[t]);
      drive_payout(amts[t], e1s[t], e50s[t], 1'b0, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL plan%0d cycle %0d: got %s, expected %s", t + 1, i + 1, fmt(obs_q[i]),
                   fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_max_amount();
    model_trace(15, 0, 0);
    drive_payout(15, 0, 0, 1'b0, 20);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL max_amount cycle %0d: got %s, expected %s", i + 1, fmt(obs_q[i]),
                 fmt(exp_q[i]));
      end
    end
    checks++;
    if (obs_q[48].done !== 1'b1) begin
      errors++;
      $display("FAIL max_latency: done at cycle 49 is %b, expected 1", obs_q[48].done);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    start_i = 1'b1;
    amount_i = AMT_W'(4);
    tube_1e_empty_i = 1'b0;
    tube_50_empty_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    o = sample();
    checks++;
    if (o !== mk(2'b10, 1, 0, 0, 2)) begin
      errors++;
      $display("FAIL rst_mid_c1: got %s, expected %s", fmt(o), fmt(mk(2'b10, 1, 0, 0, 2)));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = sample();
      checks++;
      if (o !== mk(2'b00, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL rst_mid_idle cycle %0d: got %s, expected all zero", i + 3, fmt(o));
      end
      @(posedge clk);
      #1;
    end
    model_trace(4, 0, 0);
    drive_payout(4, 0, 0, 1'b0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_rerun cycle %0d: got %s, expected %s", i + 1, fmt(obs_q[i]),
                 fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    int amt;
    bit e1, e50;
    for (int t = 0; t < 40; t++) begin
      amt = int'($urandom_range(0, 15));
      e1  = ($urandom_range(0, 3) == 0);
      e50 = ($urandom_range(0, 3) == 0);
      model_trace(amt, e1, e50);
      drive_payout(amt, e1, e50, 1'b1, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random t%0d amt=%0d e1=%b e50=%b cycle %0d: got %s, expected %s", t,
                   amt, e1, e50, i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int amts[4] = '{1, 2, 0, 5};
    for (int t = 0; t < 4; t++) begin
      model_trace(amts[t], 0, 0);
      drive_payout(amts[t], 0, 0, 1'b1, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL back_to_back t%0d cycle %0d: got %s, expected %s", t, i + 1,
                   fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_table();
    test_max_amount();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
